// File: rtl/cordic_pkg.sv
// Shared types and default widths for the CORDIC square-root result checker.
package cordic_pkg;

    localparam int ROOT_W_DEF = 16;
    localparam int RAD_W_DEF  = 2 * ROOT_W_DEF;
    localparam int CNT_W_DEF  = $clog2(ROOT_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit-counter width; a 1-bit root still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sqrt_bound_cmp.sv
// Floor-square-root bound check: acc <= radicand < acc + 2*root + 1.
// Purely combinational; the remainder is forced to zero on a failed check.
module sqrt_bound_cmp
    import cordic_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF,
    parameter int RAD_W  = RAD_W_DEF
) (
    input  logic [RAD_W-1:0]  acc,
    input  logic [ROOT_W-1:0] root,
    input  logic [RAD_W-1:0]  radicand,
    output logic              pass,
    output logic [RAD_W:0]    remainder
);

    logic [RAD_W:0] acc_x;
    logic [RAD_W:0] rad_x;
    logic [RAD_W:0] root_x2;
    logic [RAD_W:0] upper;
    logic           lo_ok;
    logic           hi_ok;

    // (root+1)^2 = root^2 + 2*root + 1; one extra bit keeps it from wrapping.
    always_comb begin
        acc_x   = {1'b0, acc};
        rad_x   = {1'b0, radicand};
        root_x2 = (RAD_W + 1)'(root) << 1;
        upper   = acc_x + root_x2 + (RAD_W + 1)'(1);
        lo_ok   = (acc_x <= rad_x);
        hi_ok   = (rad_x < upper);
        pass    = lo_ok && hi_ok;
        remainder = pass ? (rad_x - acc_x) : '0;
    end

endmodule

// File: rtl/cordic_sqrt_check.sv
// Checks a reported root against its radicand: squares the root with a
// bit-serial shift-add multiplier, then verifies it is the exact floor root.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; operands latched on start
// ST_MUL   | one root bit per cycle, LSB first, accumulating root<<cnt
// ST_CHECK | bound compare; square/pass/remainder registered
// ST_DONE  | ready pulse; start here is accepted as in ST_IDLE
module cordic_sqrt_check
    import cordic_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF,
    parameter int RAD_W  = RAD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROOT_W-1:0] root,
    input  logic [RAD_W-1:0]  radicand,
    output logic [RAD_W-1:0]  square,
    output logic [RAD_W:0]    remainder,
    output logic              pass,
    output logic              ready,
    output logic              busy
);

    localparam int CNT_W = cnt_width(ROOT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

    state_e            state_q, state_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [RAD_W-1:0]  rad_q, rad_d;
    logic [RAD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAD_W-1:0]  square_q, square_d;
    logic [RAD_W:0]    rem_q, rem_d;
    logic              pass_q, pass_d;

    logic              accept;
    logic              cmp_pass;
    logic [RAD_W:0]    cmp_rem;

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    sqrt_bound_cmp #(
        .ROOT_W (ROOT_W),
        .RAD_W  (RAD_W)
    ) u_bound (
        .acc       (acc_q),
        .root      (root_q),
        .radicand  (rad_q),
        .pass      (cmp_pass),
        .remainder (cmp_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_MUL;
            ST_MUL:   if (cnt_q == CNT_LAST) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = accept ? ST_MUL : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_MUL) || (state_q == ST_CHECK);
        ready = (state_q == ST_DONE);
    end

    always_comb begin
        root_d   = root_q;
        rad_d    = rad_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        rem_d    = rem_q;
        pass_d   = pass_q;

        if (accept) begin
            root_d = root;
            rad_d  = radicand;
            acc_d  = '0;
            cnt_d  = '0;
        end else if (state_q == ST_MUL) begin
            if (root_q[cnt_q]) begin
                acc_d = acc_q + (RAD_W'(root_q) << cnt_q);
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == ST_CHECK) begin
            square_d = acc_q;
            pass_d   = cmp_pass;
            rem_d    = cmp_rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_q   <= '0;
            rad_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            square_q <= '0;
            rem_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            root_q   <= root_d;
            rad_q    <= rad_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
            rem_q    <= rem_d;
            pass_q   <= pass_d;
        end
    end

    assign square    = square_q;
    assign remainder = rem_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_cordic_sqrt_check.sv
// Directed bench for cordic_sqrt_check: arithmetic reference model, a
// per-cycle busy/ready/result compare, and literal expectations per vector.
module tb_cordic_sqrt_check;

    localparam int ROOT_W = 16;
    localparam int RAD_W  = 32;
    localparam int LAT    = ROOT_W + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ROOT_W-1:0] root;
    logic [RAD_W-1:0]  radicand;
    logic [RAD_W-1:0]  square;
    logic [RAD_W:0]    remainder;
    logic              pass;
    logic              ready;
    logic              busy;

    cordic_sqrt_check #(
        .ROOT_W (ROOT_W),
        .RAD_W  (RAD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .root      (root),
        .radicand  (radicand),
        .square    (square),
        .remainder (remainder),
        .pass      (pass),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [RAD_W-1:0] sq;
        logic             ok;
        logic [RAD_W:0]   rem;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model(input logic [ROOT_W-1:0] r, input logic [RAD_W-1:0] x, input int due);
        exp_t    e;
        longint  sq;
        longint  nxt;
        sq  = longint'(r) * longint'(r);
        nxt = (longint'(r) + 1) * (longint'(r) + 1);
        e.due = due;
        e.sq  = sq[RAD_W-1:0];
        e.ok  = (sq <= longint'(x)) && (longint'(x) < nxt);
        e.rem = e.ok ? (RAD_W + 1)'(longint'(x) - sq) : '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Call just after a negedge; start is sampled at the following posedge.
    task automatic launch(input logic [ROOT_W-1:0] r, input logic [RAD_W-1:0] x);
        root     = r;
        radicand = x;
        start    = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(r, x, cyc + LAT));
        start = 1'b0;
    endtask

    // Returns at the negedge where ready is seen, counting busy cycles before it.
    task automatic wait_done(output int nbusy);
        bit found;
        found = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                found = 1;
                break;
            end
            if (busy) nbusy++;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL ready_timeout: no ready within 40 cycles");
        end
    endtask

    task automatic expect_res(input string name, input logic [RAD_W-1:0] sq,
                              input logic ok, input logic [RAD_W:0] rem);
        chk({name, ".square"}, 64'(square), 64'(sq));
        chk({name, ".pass"}, 64'(pass), 64'(ok));
        chk({name, ".remainder"}, 64'(remainder), 64'(rem));
    endtask

    task automatic expect_zero_outputs(input string name);
        chk({name, ".square"}, 64'(square), 64'd0);
        chk({name, ".remainder"}, 64'(remainder), 64'd0);
        chk({name, ".pass"}, 64'(pass), 64'd0);
        chk({name, ".ready"}, 64'(ready), 64'd0);
        chk({name, ".busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int nb;

        rst_n    = 1'b0;
        start    = 1'b0;
        root     = '0;
        radicand = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk("reset_outputs", {59'd0, busy, ready, pass, |square, |remainder}, 64'd0);
                end else begin
                    bit eb;
                    bit er;
                    eb = (q.size() > 0) && (cyc >= q[0].due - LAT) && (cyc < q[0].due);
                    er = (q.size() > 0) && (q[0].due == cyc);
                    chk("busy_cycle", 64'(busy), 64'(eb));
                    chk("ready_cycle", 64'(ready), 64'(er));
                    if (er) begin
                        chk("model.square", 64'(square), 64'(q[0].sq));
                        chk("model.pass", 64'(pass), 64'(q[0].ok));
                        chk("model.remainder", 64'(remainder), 64'(q[0].rem));
                        void'(q.pop_front());
                    end
                end
            end
            begin
                #200us;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        expect_zero_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'd3, 32'd9);
        wait_done(nb);
        chk("busy_len_3_9", 64'(nb), 64'd17);
        expect_res("r3_x9", 32'd9, 1'b1, 33'd0);

        @(negedge clk);
        launch(16'd2, 32'd9);
        wait_done(nb);
        expect_res("r2_x9", 32'd4, 1'b0, 33'd0);

        @(negedge clk);
        launch(16'd4, 32'd16);
        wait_done(nb);
        expect_res("r4_x16", 32'd16, 1'b1, 33'd0);

        @(negedge clk);
        launch(16'd4, 32'd24);
        wait_done(nb);
        expect_res("r4_x24", 32'd16, 1'b1, 33'd8);

        @(negedge clk);
        launch(16'd4, 32'd25);
        wait_done(nb);
        expect_res("r4_x25", 32'd16, 1'b0, 33'd0);

        @(negedge clk);
        launch(16'hFFFF, 32'hFFFF_FFFF);
        wait_done(nb);
        expect_res("rmax_xmax", 32'hFFFE_0001, 1'b1, 33'h1_FFFE);

        @(negedge clk);
        launch(16'd0, 32'd0);
        wait_done(nb);
        expect_res("r0_x0", 32'd0, 1'b1, 33'd0);

        @(negedge clk);
        launch(16'd0, 32'd1);
        wait_done(nb);
        expect_res("r0_x1", 32'd0, 1'b0, 33'd0);

        // start during MUL must not disturb the latched operands
        @(negedge clk);
        launch(16'd3, 32'd10);
        repeat (3) @(negedge clk);
        root     = 16'd5;
        radicand = 32'd99;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(nb);
        expect_res("ignored_start", 32'd9, 1'b1, 33'd1);

        // reset 8 cycles into a check aborts it with no ready pulse
        @(negedge clk);
        launch(16'd3, 32'd9);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        expect_zero_outputs("mid_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        launch(16'd6, 32'd40);
        wait_done(nb);
        expect_res("after_reset", 32'd36, 1'b1, 33'd4);

        // back-to-back: new start accepted in the DONE cycle
        @(negedge clk);
        launch(16'd7, 32'd50);
        wait_done(nb);
        expect_res("b2b_first", 32'd49, 1'b1, 33'd1);
        launch(16'd10, 32'd100);
        wait_done(nb);
        chk("busy_len_b2b", 64'(nb), 64'd17);
        expect_res("b2b_second", 32'd100, 1'b1, 33'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
